// File: rtl/draw_menu_frame.sv
// Menu-screen renderer: border, background and a vertical stack of selectable items with a
// highlight cursor and confirm-hold FSM. `define MENU_BLINK_EN to make the highlight outline blink.
module draw_menu_frame #(
    parameter int          H_RES          = 800,
    parameter int          V_RES          = 600,
    parameter int          BORDER_W       = 3,
    parameter logic [11:0] BORDER_COLOR   = 12'hF00,
    parameter logic [11:0] BG_COLOR       = 12'h888,
    parameter int          N_ITEMS        = 4,
    parameter int          ITEM_X         = 300,
    parameter int          ITEM_Y0        = 150,
    parameter int          ITEM_W         = 200,
    parameter int          ITEM_H         = 60,
    parameter int          ITEM_GAP       = 20,
    parameter logic [11:0] ITEM_COLOR     = 12'h444,
    parameter logic [11:0] HL_COLOR       = 12'hFF0,
    parameter int          HL_W           = 2,
    parameter int          CONFIRM_FRAMES = 30,
    parameter int          BLINK_FRAMES   = 16,
    localparam int         SW             = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic          hblnk_in,
    input  logic          vblnk_in,
    input  logic          key_up,
    input  logic          key_down,
    input  logic          key_select,
    output logic [10:0]   hcount_out,
    output logic [9:0]    vcount_out,
    output logic          hblnk_out,
    output logic          vblnk_out,
    output logic [11:0]   rgb_out,
    output logic [SW-1:0] sel_idx,
    output logic          sel_valid,
    output logic          busy,
    output logic          dbg_state
);
    localparam int CW = (CONFIRM_FRAMES > 1) ? $clog2(CONFIRM_FRAMES) : 1;

    typedef enum logic {BROWSE = 1'b0, CONFIRM = 1'b1} state_t;

    state_t        r_state, w_state_next;
    logic [SW-1:0] r_sel, w_sel_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_sel_valid, w_valid_next;
    logic          r_vblnk_d;
    logic          w_tick;
    logic          w_outline_vis;
    logic [11:0]   w_rgb;
    logic          w_border, w_in_any, w_in_sel, w_sel_edge;
    int            w_h, w_v, w_yi;

    assign w_tick = vblnk_in & ~r_vblnk_d;

    // State register plus all registered datapath; timing outputs share the RGB delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BROWSE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_sel_valid <= 1'b0;
            r_vblnk_d   <= 1'b0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            rgb_out     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_cnt       <= w_cnt_next;
            r_sel_valid <= w_valid_next;
            r_vblnk_d   <= vblnk_in;
            hcount_out  <= hcount_in;
            vcount_out  <= vcount_in;
            hblnk_out   <= hblnk_in;
            vblnk_out   <= vblnk_in;
            rgb_out     <= w_rgb;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        w_valid_next = 1'b0;
        case (r_state)
            BROWSE: begin
                if (key_select) begin
                    w_state_next = CONFIRM;
                    w_cnt_next   = '0;
                end else if (key_up && !key_down) begin
                    w_sel_next = (r_sel == '0) ? SW'(N_ITEMS - 1) : r_sel - 1'b1;
                end else if (key_down && !key_up) begin
                    w_sel_next = (r_sel == SW'(N_ITEMS - 1)) ? '0 : r_sel + 1'b1;
                end
            end
            CONFIRM: begin
                if (w_tick) begin
                    if (r_cnt == CW'(CONFIRM_FRAMES - 1)) begin
                        w_state_next = BROWSE;
                        w_cnt_next   = '0;
                        w_valid_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = BROWSE;
        endcase
    end

    // busy stays up through the sel_valid cycle, which is already back in BROWSE.
    always_comb begin
        busy      = (r_state == CONFIRM) || r_sel_valid;
        dbg_state = r_state;
        sel_idx   = r_sel;
        sel_valid = r_sel_valid;
    end

`ifdef MENU_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_vis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_vis <= 1'b1;
        end else if (w_sel_next != r_sel) begin
            r_blink_cnt <= '0;
            r_blink_vis <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_blink_vis <= ~r_blink_vis;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_outline_vis = r_blink_vis;
`else
    assign w_outline_vis = 1'b1;
`endif

    // Geometry classification of the incoming pixel.
    always_comb begin
        w_h        = int'(hcount_in);
        w_v        = int'(vcount_in);
        w_yi       = 0;
        w_in_any   = 1'b0;
        w_in_sel   = 1'b0;
        w_sel_edge = 1'b0;
        w_border   = (w_h < BORDER_W) || (w_h >= H_RES - BORDER_W) ||
                     (w_v < BORDER_W) || (w_v >= V_RES - BORDER_W);
        for (int i = 0; i < N_ITEMS; i++) begin
            w_yi = ITEM_Y0 + i * (ITEM_H + ITEM_GAP);
            if (w_h >= ITEM_X && w_h <= ITEM_X + ITEM_W - 1 &&
                w_v >= w_yi && w_v <= w_yi + ITEM_H - 1) begin
                w_in_any = 1'b1;
                if (i == int'(r_sel)) begin
                    w_in_sel   = 1'b1;
                    w_sel_edge = (w_h < ITEM_X + HL_W) || (w_h > ITEM_X + ITEM_W - 1 - HL_W) ||
                                 (w_v < w_yi + HL_W) || (w_v > w_yi + ITEM_H - 1 - HL_W);
                end
            end
        end
    end

    always_comb begin
        if (hblnk_in || vblnk_in)                        w_rgb = 12'h000;
        else if (w_border)                               w_rgb = BORDER_COLOR;
        else if (w_in_sel && r_state == CONFIRM)         w_rgb = HL_COLOR;
        else if (w_in_sel && w_sel_edge && w_outline_vis) w_rgb = HL_COLOR;
        else if (w_in_any)                               w_rgb = ITEM_COLOR;
        else                                             w_rgb = BG_COLOR;
    end
endmodule
